// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state type for the AHB-to-memory bridge.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ERR1,
        ERR2
    } bridge_st_t;

endpackage

// File: rtl/ahb_be_gen.sv
// Byte-lane enable generator: transfer size plus address low bits give the lane
// mask, and flag misaligned or wider-than-bus transfers.
module ahb_be_gen #(
    parameter  int DW = 32,
    localparam int NB = DW / 8,
    localparam int L  = $clog2(NB)
) (
    input  logic [2:0]    hsize,
    input  logic [L-1:0]  addr_lo,
    output logic [NB-1:0] be,
    output logic          misalign
);

    logic [NB-1:0] lanes;

    always_comb begin
        lanes    = '0;
        be       = '0;
        misalign = 1'b0;
        if (hsize > 3'(L)) begin
            misalign = 1'b1;
        end else begin
            lanes    = NB'((32'd1 << (32'd1 << hsize)) - 32'd1);
            be       = lanes << addr_lo;
            misalign = (addr_lo & L'((32'd1 << hsize) - 32'd1)) != '0;
        end
    end

endmodule

// File: rtl/ahb_to_mem_bridge.sv
// AHB-Lite slave to req/gnt/rvalid memory port bridge with wait states,
// byte-lane generation, two-cycle ERROR responses and an optional watchdog.
//
// state | meaning
// IDLE  | no transfer outstanding, zero-wait OKAY
// REQ   | req_o asserted, waiting for gnt_i
// WAIT  | granted, waiting for rvalid_i
// ERR1  | first ERROR cycle (hreadyout low)
// ERR2  | second ERROR cycle (hreadyout high), may accept next transfer
module ahb_to_mem_bridge
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0]   haddr_i,
    input  logic [AHB_DATA_WIDTH-1:0]   hwdata_i,
    input  logic                        hwrite_i,
    input  logic [2:0]                  hsize_i,
    input  logic [1:0]                  htrans_i,
    input  logic                        hready_i,
    output logic [AHB_DATA_WIDTH-1:0]   hrdata_o,
    output logic                        hreadyout_o,
    output logic                        hresp_o,
    output logic                        req_o,
    input  logic                        gnt_i,
    output logic                        we_o,
    output logic [AHB_DATA_WIDTH/8-1:0] be_o,
    output logic [AHB_ADDR_WIDTH-1:0]   addr_o,
    output logic [AHB_DATA_WIDTH-1:0]   wdata_o,
    input  logic                        rvalid_i,
    input  logic [AHB_DATA_WIDTH-1:0]   rdata_i,
    input  logic                        err_i
);

    localparam int NB = AHB_DATA_WIDTH / 8;
    localparam int L  = $clog2(NB);

    bridge_st_t                  state_q, state_d;
    logic [AHB_ADDR_WIDTH-1:L]   addr_q;
    logic                        we_q;
    logic [NB-1:0]               be_q;
    logic [31:0]                 wd_cnt;
    logic                        start, accept, wd_expired;
    logic [NB-1:0]               be_new;
    logic                        misalign;

    ahb_be_gen #(.DW(AHB_DATA_WIDTH)) u_be_gen (
        .hsize    (hsize_i),
        .addr_lo  (haddr_i[L-1:0]),
        .be       (be_new),
        .misalign (misalign)
    );

    assign start = hsel_i && hready_i &&
                   (htrans_i == HTRANS_NONSEQ || htrans_i == HTRANS_SEQ);
    assign accept = start && hreadyout_o;

    // Progress (gnt/rvalid) beats an expiring watchdog in the same cycle.
    assign wd_expired = (TIMEOUT_CYCLES > 0) &&
                        (wd_cnt >= 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        req_o       = 1'b0;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = misalign ? ERR1 : REQ;
            end
            REQ: begin
                req_o       = 1'b1;
                hreadyout_o = 1'b0;
                if (gnt_i)           state_d = WAIT;
                else if (wd_expired) state_d = ERR1;
            end
            WAIT: begin
                hreadyout_o = 1'b0;
                if (rvalid_i) begin
                    if (err_i) begin
                        state_d = ERR1;
                    end else begin
                        hreadyout_o = 1'b1;
                        state_d     = !start ? IDLE : (misalign ? ERR1 : REQ);
                    end
                end else if (wd_expired) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                state_d     = ERR2;
            end
            ERR2: begin
                hresp_o = 1'b1;
                state_d = !start ? IDLE : (misalign ? ERR1 : REQ);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            be_q   <= '0;
            wd_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q <= haddr_i[AHB_ADDR_WIDTH-1:L];
                we_q   <= hwrite_i;
                be_q   <= be_new;
            end
            if (state_d == REQ && state_q != REQ)
                wd_cnt <= '0;
            else if (state_q == REQ || state_q == WAIT)
                wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign addr_o   = {addr_q, L'(0)};
    assign we_o     = we_q;
    assign be_o     = be_q;
    assign wdata_o  = hwdata_i;
    assign hrdata_o = rdata_i;

endmodule

// File: tb/tb_ahb_to_mem_bridge.sv
// Directed bench for ahb_to_mem_bridge (32-bit data, 4-cycle watchdog).
module tb_ahb_to_mem_bridge;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [31:0] hwdata_i;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [1:0]  htrans_i;
    logic        hready_i;
    logic [31:0] hrdata_o;
    logic        hreadyout_o;
    logic        hresp_o;
    logic        req_o;
    logic        gnt_i;
    logic        we_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_to_mem_bridge #(
        .AHB_ADDR_WIDTH (32),
        .AHB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .hsel_i      (hsel_i),
        .haddr_i     (haddr_i),
        .hwdata_i    (hwdata_i),
        .hwrite_i    (hwrite_i),
        .hsize_i     (hsize_i),
        .htrans_i    (htrans_i),
        .hready_i    (hready_i),
        .hrdata_o    (hrdata_o),
        .hreadyout_o (hreadyout_o),
        .hresp_o     (hresp_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .we_o        (we_o),
        .be_o        (be_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rvalid_i    (rvalid_i),
        .rdata_i     (rdata_i),
        .err_i       (err_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs sampled one more time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_bus(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [2:0] size, input logic [31:0] addr);
        hsel_i   = sel;
        htrans_i = trans;
        hwrite_i = wr;
        hsize_i  = size;
        haddr_i  = addr;
    endtask

    task automatic bus_idle();
        set_bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
    endtask

    task automatic set_mem(input logic gnt, input logic rv, input logic err,
                           input logic [31:0] rdata);
        gnt_i    = gnt;
        rvalid_i = rv;
        err_i    = err;
        rdata_i  = rdata;
    endtask

    initial begin
        rstn     = 1'b0;
        hready_i = 1'b1;
        hwdata_i = 32'h0;
        bus_idle();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        cyc();
        settle();
        chk("rst_hready", hreadyout_o, 1);
        chk("rst_req",    req_o,       0);
        chk("rst_be",     be_o,        0);
        chk("rst_addr",   addr_o,      0);
        chk("rst_we",     we_o,        0);
        chk("rst_hresp",  hresp_o,     0);
        rstn = 1'b1;

        // Unselected NONSEQ must not start a memory access.
        cyc();
        set_bus(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
        settle();
        cyc();
        bus_idle();
        settle();
        chk("unsel_req",    req_o,       0);
        chk("unsel_hready", hreadyout_o, 1);

        // Word read at 0x100: gnt in 2nd REQ cycle, rvalid two cycles later.
        set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h100);
        settle();
        chk("rd_addrph_hready", hreadyout_o, 1);
        cyc();
        bus_idle();
        settle();
        chk("rd_c1_req",    req_o,       1);
        chk("rd_c1_hready", hreadyout_o, 0);
        chk("rd_be",        be_o,        4'hF);
        chk("rd_addr",      addr_o,      32'h100);
        chk("rd_we",        we_o,        0);
        cyc();
        set_mem(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        chk("rd_c2_req",    req_o,       1);
        chk("rd_c2_hready", hreadyout_o, 0);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("rd_c3_req",    req_o,       0);
        chk("rd_c3_hready", hreadyout_o, 0);
        cyc();
        set_mem(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        settle();
        chk("rd_c4_hready", hreadyout_o, 1);
        chk("rd_c4_hresp",  hresp_o,     0);
        chk("rd_c4_hrdata", hrdata_o,    32'hDEADBEEF);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("rd_done_req",    req_o,       0);
        chk("rd_done_hready", hreadyout_o, 1);

        // Byte write at 0x203.
        set_bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h203);
        settle();
        cyc();
        bus_idle();
        hwdata_i = 32'hAB000000;
        set_mem(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        chk("wr_req",   req_o,   1);
        chk("wr_be",    be_o,    4'b1000);
        chk("wr_addr",  addr_o,  32'h200);
        chk("wr_we",    we_o,    1);
        chk("wr_wdata", wdata_o, 32'hAB000000);
        cyc();
        set_mem(1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("wr_ok_hready", hreadyout_o, 1);
        chk("wr_ok_hresp",  hresp_o,     0);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        hwdata_i = 32'h0;
        settle();
        chk("wr_done_hready", hreadyout_o, 1);

        // Misaligned halfword at 0x101, then doubleword on a 32-bit bus.
        for (int t = 0; t < 2; t++) begin
            if (t == 0) set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h101);
            else        set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 32'h0);
            settle();
            cyc();
            bus_idle();
            settle();
            chk($sformatf("mis%0d_e1_req", t),    req_o,       0);
            chk($sformatf("mis%0d_e1_hready", t), hreadyout_o, 0);
            chk($sformatf("mis%0d_e1_hresp", t),  hresp_o,     1);
            cyc();
            settle();
            chk($sformatf("mis%0d_e2_req", t),    req_o,       0);
            chk($sformatf("mis%0d_e2_hready", t), hreadyout_o, 1);
            chk($sformatf("mis%0d_e2_hresp", t),  hresp_o,     1);
            cyc();
            settle();
            chk($sformatf("mis%0d_idle_hresp", t), hresp_o, 0);
        end

        // Back-to-back NONSEQ reads 0x0 and 0x4, gnt tied high.
        set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        set_mem(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        cyc();
        set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h4);
        settle();
        chk("b2b_c1_req",    req_o,       1);
        chk("b2b_c1_addr",   addr_o,      32'h0);
        chk("b2b_c1_hready", hreadyout_o, 0);
        cyc();
        set_mem(1'b1, 1'b1, 1'b0, 32'h11111111);
        settle();
        chk("b2b_c2_hready", hreadyout_o, 1);
        chk("b2b_c2_hrdata", hrdata_o,    32'h11111111);
        chk("b2b_c2_req",    req_o,       0);
        cyc();
        bus_idle();
        set_mem(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        chk("b2b_c3_req",    req_o,       1);
        chk("b2b_c3_addr",   addr_o,      32'h4);
        chk("b2b_c3_hready", hreadyout_o, 0);
        cyc();
        set_mem(1'b1, 1'b1, 1'b0, 32'h22222222);
        settle();
        chk("b2b_c4_hready", hreadyout_o, 1);
        chk("b2b_c4_hrdata", hrdata_o,    32'h22222222);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("b2b_done_req", req_o, 0);

        // Memory error on rvalid.
        set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8);
        settle();
        cyc();
        bus_idle();
        set_mem(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        cyc();
        set_mem(1'b0, 1'b1, 1'b1, 32'h0);
        settle();
        chk("merr_rv_hready", hreadyout_o, 0);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("merr_e1_hready", hreadyout_o, 0);
        chk("merr_e1_hresp",  hresp_o,     1);
        cyc();
        settle();
        chk("merr_e2_hready", hreadyout_o, 1);
        chk("merr_e2_hresp",  hresp_o,     1);
        cyc();
        settle();

        // Watchdog: gnt never arrives.
        set_bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'hC);
        settle();
        cyc();
        bus_idle();
        settle();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("wd_req_c%0d", i), req_o, 1);
            cyc();
            settle();
        end
        chk("wd_e1_req",    req_o,       0);
        chk("wd_e1_hready", hreadyout_o, 0);
        chk("wd_e1_hresp",  hresp_o,     1);
        cyc();
        settle();
        chk("wd_e2_hready", hreadyout_o, 1);
        chk("wd_e2_hresp",  hresp_o,     1);
        cyc();
        set_mem(1'b1, 1'b1, 1'b0, 32'h0);
        settle();
        chk("wd_late_hready", hreadyout_o, 1);
        chk("wd_late_hresp",  hresp_o,     0);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("wd_late_req", req_o, 0);

        // Reset while in WAIT, followed by a stray rvalid.
        set_bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
        settle();
        cyc();
        bus_idle();
        set_mem(1'b1, 1'b0, 1'b0, 32'h0);
        settle();
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        rstn = 1'b0;
        settle();
        chk("mrst_wait_hready", hreadyout_o, 0);
        cyc();
        rstn = 1'b1;
        set_mem(1'b0, 1'b1, 1'b0, 32'h0);
        settle();
        chk("mrst_hready", hreadyout_o, 1);
        chk("mrst_req",    req_o,       0);
        chk("mrst_we",     we_o,        0);
        chk("mrst_addr",   addr_o,      0);
        chk("mrst_hresp",  hresp_o,     0);
        cyc();
        set_mem(1'b0, 1'b0, 1'b0, 32'h0);
        settle();
        chk("mrst_after_req",    req_o,       0);
        chk("mrst_after_hready", hreadyout_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
